alu_op_sequencer: RTL and testbench

//  Command/result stage wrapped around the combinational alu.
//  - Accepts ALU commands over a valid/ready handshake.
//  - Drives alu opcode/a/b/cin from registers.
//  - Captures y and the flags into a result register and a NZCV status register.
//  - Can re-apply one op up to 2**REPEAT_W times, feeding y back into a
//    (multi-bit shifts, accumulate).

---
 rtl/alu_op_sequencer_if.sv | 44 ++++
 rtl/alu_op_sequencer.sv | 104 ++++++++++
 tb/tb_alu_op_sequencer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// rtl/alu_op_sequencer_if.sv - command, result and alu-side signal bundle for alu_op_sequencer
interface alu_op_sequencer_if #(
  parameter int WIDTH    = 4,
  parameter int REPEAT_W = 4
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [3:0]          cmd_opcode;
  logic [WIDTH-1:0]    cmd_a;
  logic [WIDTH-1:0]    cmd_b;
  logic                cmd_use_carry;
  logic [REPEAT_W-1:0] cmd_repeat;

  logic [3:0]          alu_opcode;
  logic [WIDTH-1:0]    alu_a;
  logic [WIDTH-1:0]    alu_b;
  logic                alu_cin;
  logic [WIDTH-1:0]    alu_y;
  logic                alu_cout;
  logic                alu_overflow;
  logic                alu_negative;
  logic                alu_zero;

  logic                res_valid;
  logic                res_ready;
  logic [WIDTH-1:0]    res_data;
  logic [3:0]          res_flags;

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_use_carry, cmd_repeat,
    input  alu_y, alu_cout, alu_overflow, alu_negative, alu_zero,
    input  res_ready,
    output cmd_ready, alu_opcode, alu_a, alu_b, alu_cin,
    output res_valid, res_data, res_flags
  );

  modport master (
    output cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_use_carry, cmd_repeat,
    output alu_y, alu_cout, alu_overflow, alu_negative, alu_zero,
    output res_ready,
    input  cmd_ready, alu_opcode, alu_a, alu_b, alu_cin,
    input  res_valid, res_data, res_flags
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - registered command/result stage around a combinational alu
module alu_op_sequencer #(
  parameter int WIDTH    = 4,
  parameter int REPEAT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  alu_op_sequencer_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]          state_q,   state_d;
  logic [3:0]          opcode_q,  opcode_d;
  logic [WIDTH-1:0]    op_a_q,    op_a_d;
  logic [WIDTH-1:0]    op_b_q,    op_b_d;
  logic                use_c_q,   use_c_d;
  logic                cin_q,     cin_d;
  logic [REPEAT_W-1:0] cnt_q,     cnt_d;
  logic [WIDTH-1:0]    res_q,     res_d;
  logic [3:0]          nzcv_q,    nzcv_d;

  logic [3:0] alu_flags;
  assign alu_flags = {bus.alu_negative, bus.alu_zero, bus.alu_cout, bus.alu_overflow};

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    use_c_d  = use_c_q;
    cin_d    = cin_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    nzcv_d   = nzcv_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          opcode_d = bus.cmd_opcode;
          op_a_d   = bus.cmd_a;
          op_b_d   = bus.cmd_b;
          use_c_d  = bus.cmd_use_carry;
          cin_d    = bus.cmd_use_carry & nzcv_q[1];
          cnt_d    = bus.cmd_repeat;
          state_d  = S_EXEC;
        end
      end
      S_EXEC: begin
        op_a_d = bus.alu_y;
        res_d  = bus.alu_y;
        nzcv_d = alu_flags;
        // cin is registered so it stays frozen once the last iteration is done
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
          cin_d = use_c_q & bus.alu_cout;
        end
      end
      S_DONE: begin
        if (bus.res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      opcode_q <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      use_c_q  <= 1'b0;
      cin_q    <= 1'b0;
      cnt_q    <= '0;
      res_q    <= '0;
      nzcv_q   <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      use_c_q  <= use_c_d;
      cin_q    <= cin_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      nzcv_q   <= nzcv_d;
    end
  end

  assign bus.cmd_ready  = (state_q == S_IDLE);
  assign bus.res_valid  = (state_q == S_DONE);
  assign bus.res_data   = res_q;
  assign bus.res_flags  = nzcv_q;
  assign bus.alu_opcode = opcode_q;
  assign bus.alu_a      = op_a_q;
  assign bus.alu_b      = op_b_q;
  assign bus.alu_cin    = cin_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed bench for alu_op_sequencer with a small alu model
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  int   lat;
  int   nys;
  logic [3:0] ys [0:31];
  logic       cin_seen;
  logic [3:0] hold_data;
  logic [3:0] hold_flags;

  always #5 clk = ~clk;

  alu_op_sequencer_if #(.WIDTH(4), .REPEAT_W(4)) bus ();

  alu_op_sequencer #(.WIDTH(4), .REPEAT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // alu model: 0 add with cin, 1 subtract, 2 arithmetic shift right by b
  logic [4:0] sum_w;
  always_comb begin
    sum_w            = 5'd0;
    bus.alu_y        = bus.alu_a;
    bus.alu_cout     = 1'b0;
    bus.alu_overflow = 1'b0;
    case (bus.alu_opcode)
      4'd0: begin
        sum_w            = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {4'd0, bus.alu_cin};
        bus.alu_y        = sum_w[3:0];
        bus.alu_cout     = sum_w[4];
        bus.alu_overflow = (bus.alu_a[3] == bus.alu_b[3]) && (sum_w[3] != bus.alu_a[3]);
      end
      4'd1: begin
        sum_w            = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 5'd1;
        bus.alu_y        = sum_w[3:0];
        bus.alu_cout     = sum_w[4];
        bus.alu_overflow = (bus.alu_a[3] != bus.alu_b[3]) && (sum_w[3] != bus.alu_a[3]);
      end
      4'd2: bus.alu_y = $signed(bus.alu_a) >>> bus.alu_b;
      default: ;
    endcase
    bus.alu_negative = bus.alu_y[3];
    bus.alu_zero     = (bus.alu_y == 4'd0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic uc, input logic [3:0] rep);
    bus.cmd_opcode    = op;
    bus.cmd_a         = a;
    bus.cmd_b         = b;
    bus.cmd_use_carry = uc;
    bus.cmd_repeat    = rep;
    bus.cmd_valid     = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    lat = 1;
    nys = 0;
    while (!bus.res_valid && lat < 40) begin
      if (nys < 32) begin
        ys[nys] = bus.alu_y;
        nys++;
      end
      cin_seen = bus.alu_cin;
      step();
      lat++;
    end
  endtask

  task automatic collect();
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    chk("collect_res_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("collect_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
  endtask

  initial begin
    reset             = 1'b1;
    bus.cmd_valid     = 1'b0;
    bus.cmd_opcode    = 4'd0;
    bus.cmd_a         = 4'd0;
    bus.cmd_b         = 4'd0;
    bus.cmd_use_carry = 1'b0;
    bus.cmd_repeat    = 4'd0;
    bus.res_ready     = 1'b0;
    step();
    step();
    chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("rst_res_data",  {28'd0, bus.res_data},  32'd0);
    chk("rst_res_flags", {28'd0, bus.res_flags}, 32'd0);
    chk("rst_alu_cin",   {31'd0, bus.alu_cin},   32'd0);
    reset = 1'b0;
    step();

    issue(4'd0, 4'b0001, 4'b0001, 1'b0, 4'd0);
    chk("add_latency",   lat, 32'd2);
    chk("add_data",      {28'd0, bus.res_data},  32'b0010);
    chk("add_flags",     {28'd0, bus.res_flags}, 32'b0000);
    chk("add_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    collect();

    issue(4'd1, 4'b0001, 4'b0001, 1'b0, 4'd0);
    chk("sub_latency", lat, 32'd2);
    chk("sub_data",    {28'd0, bus.res_data},  32'b0000);
    chk("sub_flags",   {28'd0, bus.res_flags}, 32'b0110);
    collect();

    issue(4'd2, 4'b1001, 4'b0001, 1'b0, 4'd2);
    chk("asr_latency", lat, 32'd4);
    chk("asr_iters",   nys, 32'd3);
    chk("asr_y0",      {28'd0, ys[0]}, 32'b1100);
    chk("asr_y1",      {28'd0, ys[1]}, 32'b1110);
    chk("asr_y2",      {28'd0, ys[2]}, 32'b1111);
    chk("asr_data",    {28'd0, bus.res_data},  32'b1111);
    chk("asr_flags",   {28'd0, bus.res_flags}, 32'b1000);
    collect();

    issue(4'd0, 4'b1111, 4'b0001, 1'b0, 4'd0);
    chk("carry_gen_data",  {28'd0, bus.res_data},  32'b0000);
    chk("carry_gen_flags", {28'd0, bus.res_flags}, 32'b0110);
    collect();
    issue(4'd0, 4'b0000, 4'b0000, 1'b1, 4'd0);
    chk("carry_use_cin",   {31'd0, cin_seen},      32'd1);
    chk("carry_use_data",  {28'd0, bus.res_data},  32'b0001);
    chk("carry_use_flags", {28'd0, bus.res_flags}, 32'b0000);
    collect();

    issue(4'd0, 4'b0111, 4'b0001, 1'b0, 4'd0);
    hold_data  = bus.res_data;
    hold_flags = bus.res_flags;
    chk("stall_data",  {28'd0, hold_data},  32'b1000);
    chk("stall_flags", {28'd0, hold_flags}, 32'b1001);
    bus.cmd_opcode = 4'd1;
    bus.cmd_a      = 4'b0101;
    bus.cmd_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_res_valid", {31'd0, bus.res_valid}, 32'd1);
      chk("stall_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
      chk("stall_hold_data",  {28'd0, bus.res_data},  {28'd0, 4'b1000});
      chk("stall_hold_flags", {28'd0, bus.res_flags}, {28'd0, 4'b1001});
      chk("stall_alu_op",     {28'd0, bus.alu_opcode}, 32'd0);
    end
    bus.cmd_valid = 1'b0;
    collect();

    bus.cmd_opcode    = 4'd2;
    bus.cmd_a         = 4'b1000;
    bus.cmd_b         = 4'b0001;
    bus.cmd_use_carry = 1'b0;
    bus.cmd_repeat    = 4'd15;
    bus.cmd_valid     = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    step();
    step();
    chk("abort_pre_flags", {28'd0, bus.res_flags}, 32'b1000);
    chk("abort_pre_valid", {31'd0, bus.res_valid}, 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("abort_res_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("abort_flags",     {28'd0, bus.res_flags}, 32'b0000);
    chk("abort_data",      {28'd0, bus.res_data},  32'b0000);
    step();
    chk("abort_stays_idle", {31'd0, bus.cmd_ready}, 32'd1);

    issue(4'd2, 4'b1000, 4'b0001, 1'b0, 4'd15);
    chk("rep15_latency", lat, 32'd17);
    chk("rep15_iters",   nys, 32'd16);
    chk("rep15_data",    {28'd0, bus.res_data}, 32'b1111);
    collect();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
